// File: rtl/timed_demultiplexer_1x4_pkg.sv
// rtl/timed_demultiplexer_1x4_pkg.sv - shared state encoding and zone sizing for the 1x4 timed demultiplexer
package timed_demultiplexer_1x4_pkg;

  localparam int ZONE_COUNT = 4;
  localparam int ZONE_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } demux_state_t;

endpackage

// File: rtl/timed_demultiplexer_1x4_cycle_counter.sv
// rtl/timed_demultiplexer_1x4_cycle_counter.sv - clearable up-counter with terminal-count compare against a runtime limit
module cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] count;

  // Saturates so a long manual-mode drive can never wrap back into the dwell window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == limit);

endmodule

// File: rtl/timed_demultiplexer_1x4.sv
// rtl/timed_demultiplexer_1x4.sv - routes one control bit to one of four zones with break-before-make gaps
module timed_demultiplexer_1x4
  import timed_demultiplexer_1x4_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in,
  input  logic                  enable,
  input  logic                  auto,
  input  logic [ZONE_WIDTH-1:0] selector,
  output logic [ZONE_COUNT-1:0] out,
  output logic [ZONE_WIDTH-1:0] zone,
  output logic                  switching
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_WIDTH  = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] DWELL_LIMIT = CNT_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LIMIT   = CNT_WIDTH'(GAP_CYCLES - 1);

  demux_state_t          state;
  demux_state_t          state_next;
  logic [ZONE_WIDTH-1:0] zone_next;
  logic [ZONE_WIDTH-1:0] target_zone;
  logic [CNT_WIDTH-1:0]  cnt_limit;
  logic                  cnt_clear;
  logic                  cnt_inc;
  logic                  cnt_terminal;
  logic                  auto_q;
  logic                  auto_rise;

  assign auto_rise   = auto && !auto_q;
  assign target_zone = auto ? (zone + ZONE_WIDTH'(1)) : selector;
  assign cnt_limit   = (state == GAP) ? GAP_LIMIT : DWELL_LIMIT;
  assign cnt_inc     = (state != IDLE);

  cycle_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cycle_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .limit    (cnt_limit),
    .terminal (cnt_terminal)
  );

  // Enable loss always wins and skips the gap; otherwise mode decides when to leave DRIVE.
  always_comb begin
    state_next = state;
    zone_next  = zone;
    cnt_clear  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (enable) begin
          state_next = DRIVE;
          zone_next  = selector;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (auto) begin
          if (auto_rise) begin
            cnt_clear = 1'b1;
          end else if (cnt_terminal) begin
            state_next = GAP;
            cnt_clear  = 1'b1;
          end
        end else if (selector != zone) begin
          state_next = GAP;
          cnt_clear  = 1'b1;
        end
      end
      GAP: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (cnt_terminal) begin
          state_next = DRIVE;
          zone_next  = target_zone;
          cnt_clear  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // Outputs decode the pre-edge state, so a zone is only driven once DRIVE has been held a full cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      zone      <= '0;
      auto_q    <= 1'b0;
      out       <= '0;
      switching <= 1'b0;
    end else begin
      state     <= state_next;
      zone      <= zone_next;
      auto_q    <= auto;
      out       <= ((state == DRIVE) && in) ? (ZONE_COUNT'(1) << zone) : '0;
      switching <= (state == GAP);
    end
  end

endmodule

// File: tb/tb_timed_demultiplexer_1x4.sv
// tb/tb_timed_demultiplexer_1x4.sv - directed bench for timed_demultiplexer_1x4 with a countdown reference model
module tb_timed_demultiplexer_1x4;

  typedef struct {
    bit active;
    int zone;
    int gap_left;
    int dwell_used;
    bit prev_auto;
    int exp_out;
    int exp_zone;
    int exp_sw;
  } model_t;

  logic       clock;
  logic       reset_n;
  logic       din;
  logic       enable;
  logic       auto_mode;
  logic [1:0] selector;
  logic [3:0] out_a, out_b;
  logic [1:0] zone_a, zone_b;
  logic       sw_a, sw_b;
  bit         check_en;
  int         vectors;
  int         errors;
  model_t     ma, mb;
  logic [4:0] vec [0:15];

  timed_demultiplexer_1x4 #(.DWELL_CYCLES(3), .GAP_CYCLES(1)) dut_a (
    .clock (clock), .reset_n (reset_n), .in (din), .enable (enable), .auto (auto_mode),
    .selector (selector), .out (out_a), .zone (zone_a), .switching (sw_a)
  );

  timed_demultiplexer_1x4 #(.DWELL_CYCLES(3), .GAP_CYCLES(3)) dut_b (
    .clock (clock), .reset_n (reset_n), .in (din), .enable (enable), .auto (auto_mode),
    .selector (selector), .out (out_b), .zone (zone_b), .switching (sw_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void model_reset(inout model_t m);
    m.active = 0; m.zone = 0; m.gap_left = 0; m.dwell_used = 0; m.prev_auto = 0;
    m.exp_out = 0; m.exp_zone = 0; m.exp_sw = 0;
  endfunction

  // Outputs after an edge reflect what the zone was doing during the cycle that just ended.
  function automatic void model_step(inout model_t m, input int dwell, input int gap,
                                     input bit en, input bit au, input int sel, input bit d);
    m.exp_out = (m.active && m.gap_left == 0 && d) ? (1 << m.zone) : 0;
    m.exp_sw  = (m.active && m.gap_left > 0) ? 1 : 0;
    if (!en) begin
      m.active = 0;
      m.gap_left = 0;
    end else if (!m.active) begin
      m.active = 1;
      m.zone = sel;
      m.dwell_used = 0;
    end else if (m.gap_left > 0) begin
      m.gap_left--;
      if (m.gap_left == 0) begin
        m.zone = au ? (m.zone + 1) % 4 : sel;
        m.dwell_used = 0;
      end
    end else if (au && !m.prev_auto) begin
      m.dwell_used = 0;
    end else if (au) begin
      m.dwell_used++;
      if (m.dwell_used == dwell) m.gap_left = gap;
    end else if (sel != m.zone) begin
      m.gap_left = gap;
    end
    m.prev_auto = au;
    m.exp_zone = m.zone;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_reset(ma);
      model_reset(mb);
    end else begin
      model_step(ma, 3, 1, enable, auto_mode, int'(selector), din);
      model_step(mb, 3, 3, enable, auto_mode, int'(selector), din);
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("model_out_a", 32'(out_a), 32'(ma.exp_out));
      check("model_zone_a", 32'(zone_a), 32'(ma.exp_zone));
      check("model_sw_a", 32'(sw_a), 32'(ma.exp_sw));
      check("model_out_b", 32'(out_b), 32'(mb.exp_out));
      check("model_zone_b", 32'(zone_b), 32'(mb.exp_zone));
      check("model_sw_b", 32'(sw_b), 32'(mb.exp_sw));
    end
  end

  initial begin
    vectors = 0; errors = 0; check_en = 0;
    reset_n = 1'b1; din = 1'b0; enable = 1'b0; auto_mode = 1'b0; selector = 2'd0;
    vec = '{5'b10000, 5'b10011, 5'b10010, 5'b10111, 5'b10110, 5'b00111, 5'b10001, 5'b11001,
            5'b11011, 5'b11010, 5'b01011, 5'b10101, 5'b10101, 5'b11111, 5'b10011, 5'b00000};
    #2 reset_n = 1'b0;
    tick(2);
    check("reset_out", 32'(out_a), 32'h0);
    check("reset_zone", 32'(zone_a), 32'h0);
    check("reset_sw", 32'(sw_a), 32'h0);
    check_en = 1;
    reset_n = 1'b1;

    enable = 1'b1; selector = 2'd2; din = 1'b1;
    tick(2);
    check("manual_out", 32'(out_a), 32'b0100);
    check("manual_zone", 32'(zone_a), 32'd2);
    din = 1'b0;
    tick(1);
    check("lag_low", 32'(out_a), 32'b0000);
    din = 1'b1;
    tick(1);
    check("lag_high", 32'(out_a), 32'b0100);

    selector = 2'd1;
    tick(2);
    check("gap_out", 32'(out_a), 32'b0000);
    check("gap_sw", 32'(sw_a), 32'd1);
    tick(1);
    check("switch_out", 32'(out_a), 32'b0010);
    check("switch_zone", 32'(zone_a), 32'd1);
    check("switch_sw", 32'(sw_a), 32'd0);

    selector = 2'd3;
    tick(1);
    check("late_zone_b", 32'(zone_b), 32'd3);
    check("late_sw_b", 32'(sw_b), 32'd1);
    tick(1);
    check("late_out_b", 32'(out_b), 32'b1000);
    check("follow_zone_a", 32'(zone_a), 32'd3);
    check("follow_out_a", 32'(out_a), 32'b0000);

    enable = 1'b0;
    tick(2);
    check("disable_out", 32'(out_a), 32'b0000);
    auto_mode = 1'b1; selector = 2'd3; enable = 1'b1;
    tick(1);
    check("auto_start_zone", 32'(zone_a), 32'd3);
    tick(1);
    check("auto_z3_out", 32'(out_a), 32'b1000);
    tick(3);
    check("auto_gap_out", 32'(out_a), 32'b0000);
    check("auto_gap_sw", 32'(sw_a), 32'd1);
    check("auto_wrap_zone", 32'(zone_a), 32'd0);
    tick(1);
    check("auto_z0_out", 32'(out_a), 32'b0001);
    tick(4);
    check("auto_z1_out", 32'(out_a), 32'b0010);
    check("auto_z1_zone", 32'(zone_a), 32'd1);
    check("auto_b_z0_out", 32'(out_b), 32'b0001);

    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(3);
    check("prio_pre_out", 32'(out_a), 32'b1000);
    enable = 1'b0;
    tick(1);
    check("prio_edge_out", 32'(out_a), 32'b1000);
    check("prio_edge_sw", 32'(sw_a), 32'd0);
    tick(1);
    check("prio_off_out", 32'(out_a), 32'b0000);
    check("prio_off_sw", 32'(sw_a), 32'd0);
    check("prio_zone", 32'(zone_a), 32'd3);

    auto_mode = 1'b0; selector = 2'd2; enable = 1'b1; din = 1'b1;
    tick(2);
    check("pre_reset_out", 32'(out_a), 32'b0100);
    #2 reset_n = 1'b0;
    #1;
    check("async_out", 32'(out_a), 32'h0);
    check("async_zone", 32'(zone_a), 32'h0);
    check("async_sw", 32'(sw_a), 32'h0);
    tick(2);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      {enable, auto_mode, selector, din} = vec[i];
      tick(3);
    end
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
